// File: rtl/blt_pkg.sv
// Shared types and constants for the blitter address-step sequencer.
// State encoding, address-delta constants and mode-register bit positions.
package blt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INNER = 2'd1,
    ST_OUTER = 2'd2,
    ST_DONE  = 2'd3
  } blt_state_t;

  localparam logic [8:0] DELTA_P1 = 9'h001;
  localparam logic [8:0] DELTA_M1 = 9'h1FF;
  localparam logic [8:0] DELTA_0  = 9'h000;

  localparam int MODE_STEPM1_BIT = 0;
  localparam int MODE_YFRAC_BIT  = 4;

endpackage

// File: rtl/blt_step_regs.sv
// Step, mode and loop-count registers loaded from the internal data bus.
// Writes take effect on the strobe edge and are dropped while a sequence is busy.
module blt_step_regs
  import blt_pkg::*;
#(
  parameter int CW = 8,
  parameter int FW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    id,
  input  logic          ldstpl,
  input  logic          ldmodl,
  input  logic          ldinnl,
  input  logic          ldoutl,
  input  logic          busy,
  output logic [FW-1:0] step,
  output logic          stepm1,
  output logic          yfrac,
  output logic [CW-1:0] inner_cnt,
  output logic [CW-1:0] outer_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step      <= '0;
      stepm1    <= 1'b0;
      yfrac     <= 1'b0;
      inner_cnt <= '0;
      outer_cnt <= '0;
    end else if (!busy) begin
      if (!ldstpl) step <= FW'(id);
      if (!ldmodl) begin
        stepm1 <= id[MODE_STEPM1_BIT];
        yfrac  <= id[MODE_YFRAC_BIT];
      end
      if (!ldinnl) inner_cnt <= CW'(id);
      if (!ldoutl) outer_cnt <= CW'(id);
    end
  end

endmodule

// File: rtl/blt_step_seq.sv
// Inner/outer address-step sequencer: one signed delta per ADV_REQ/ADV_ACK handshake.
// Request and delta are registered and held until acked; ABORT returns to idle silently.
module blt_step_seq
  import blt_pkg::*;
#(
  parameter int CW = 8,
  parameter int FW = 8
) (
  input  logic          CLK,
  input  logic          RESETL,
  input  logic [7:0]    ID,
  input  logic          LDSTPL,
  input  logic          LDMODL,
  input  logic          LDINNL,
  input  logic          LDOUTL,
  input  logic          START,
  input  logic          ABORT,
  input  logic          ADV_ACK,
  output logic [FW-1:0] STEP,
  output logic          STEPM1,
  output logic          YFRAC,
  output logic          BUSY,
  output logic          ADV_REQ,
  output logic          OUTER,
  output logic [FW:0]   DELTA,
  output logic          DONE
);

  localparam int DW = FW + 1;

  blt_state_t    state;
  logic [CW-1:0] inner_cnt, outer_cnt;
  logic [CW-1:0] icnt, ocnt;
  logic [FW-1:0] frac;
  logic [FW:0]   frac_sum;
  logic [FW:0]   outer_delta;

  blt_step_regs #(.CW(CW), .FW(FW)) u_regs (
    .clk       (CLK),
    .rst_n     (RESETL),
    .id        (ID),
    .ldstpl    (LDSTPL),
    .ldmodl    (LDMODL),
    .ldinnl    (LDINNL),
    .ldoutl    (LDOUTL),
    .busy      (BUSY),
    .step      (STEP),
    .stepm1    (STEPM1),
    .yfrac     (YFRAC),
    .inner_cnt (inner_cnt),
    .outer_cnt (outer_cnt)
  );

  // In Y-fraction mode the outer line only moves when the accumulator carries.
  always_comb begin
    frac_sum = {1'b0, frac} + {1'b0, STEP};
    if (YFRAC)
      outer_delta = frac_sum[FW] ? (STEPM1 ? DW'(DELTA_M1) : DW'(DELTA_P1)) : DW'(DELTA_0);
    else
      outer_delta = STEPM1 ? -{1'b0, STEP} : {1'b0, STEP};
  end

  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      state   <= ST_IDLE;
      icnt    <= '0;
      ocnt    <= '0;
      frac    <= '0;
      BUSY    <= 1'b0;
      ADV_REQ <= 1'b0;
      OUTER   <= 1'b0;
      DELTA   <= '0;
      DONE    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (START) begin
            if (inner_cnt != '0 && outer_cnt != '0) begin
              state   <= ST_INNER;
              icnt    <= inner_cnt;
              ocnt    <= outer_cnt;
              frac    <= '0;
              BUSY    <= 1'b1;
              ADV_REQ <= 1'b1;
              OUTER   <= 1'b0;
              DELTA   <= DW'(DELTA_P1);
            end else begin
              state <= ST_DONE;
              DONE  <= 1'b1;
            end
          end
        end
        ST_INNER: begin
          if (ABORT) begin
            state   <= ST_IDLE;
            BUSY    <= 1'b0;
            ADV_REQ <= 1'b0;
            DELTA   <= '0;
          end else if (ADV_ACK) begin
            icnt <= icnt - 1'b1;
            if (icnt == CW'(1)) begin
              state <= ST_OUTER;
              OUTER <= 1'b1;
              DELTA <= outer_delta;
            end
          end
        end
        ST_OUTER: begin
          if (ABORT) begin
            state   <= ST_IDLE;
            BUSY    <= 1'b0;
            ADV_REQ <= 1'b0;
            OUTER   <= 1'b0;
            DELTA   <= '0;
          end else if (ADV_ACK) begin
            ocnt <= ocnt - 1'b1;
            if (YFRAC) frac <= frac_sum[FW-1:0];
            OUTER <= 1'b0;
            if (ocnt == CW'(1)) begin
              state   <= ST_DONE;
              DONE    <= 1'b1;
              BUSY    <= 1'b0;
              ADV_REQ <= 1'b0;
              DELTA   <= '0;
            end else begin
              state <= ST_INNER;
              icnt  <= inner_cnt;
              DELTA <= DW'(DELTA_P1);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blt_step_seq.sv
// Directed bench for blt_step_seq: stepping, negative step, Y-fraction, zero count,
// abort, busy write gating and asynchronous reset.
module tb_blt_step_seq;

  logic       CLK = 1'b0;
  logic       RESETL;
  logic [7:0] ID;
  logic       LDSTPL, LDMODL, LDINNL, LDOUTL;
  logic       START, ABORT, ADV_ACK;
  logic [7:0] STEP;
  logic       STEPM1, YFRAC, BUSY, ADV_REQ, OUTER, DONE;
  logic [8:0] DELTA;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] got_d [32];
  logic       got_o [32];
  int         got_n;

  always #5 CLK = ~CLK;

  blt_step_seq dut (
    .CLK(CLK), .RESETL(RESETL), .ID(ID),
    .LDSTPL(LDSTPL), .LDMODL(LDMODL), .LDINNL(LDINNL), .LDOUTL(LDOUTL),
    .START(START), .ABORT(ABORT), .ADV_ACK(ADV_ACK),
    .STEP(STEP), .STEPM1(STEPM1), .YFRAC(YFRAC), .BUSY(BUSY),
    .ADV_REQ(ADV_REQ), .OUTER(OUTER), .DELTA(DELTA), .DONE(DONE)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic setup(input logic [7:0] step, input logic m1, input logic yf,
                       input logic [7:0] inner, input logic [7:0] outer);
    ID = step;  LDSTPL = 1'b0; tick(); LDSTPL = 1'b1;
    ID = {3'b000, yf, 3'b000, m1}; LDMODL = 1'b0; tick(); LDMODL = 1'b1;
    ID = inner; LDINNL = 1'b0; tick(); LDINNL = 1'b1;
    ID = outer; LDOUTL = 1'b0; tick(); LDOUTL = 1'b1;
  endtask

  // Start with ADV_ACK held high and record every request up to the DONE pulse.
  task automatic run_collect(input string name);
    bit seen_done = 1'b0;
    got_n = 0;
    ADV_ACK = 1'b1;
    START = 1'b1; tick(); START = 1'b0;
    check({name, "_busy_start"}, 16'(BUSY), 16'h1);
    for (int c = 0; c < 100; c++) begin
      if (DONE) begin
        seen_done = 1'b1;
        break;
      end
      if (ADV_REQ && got_n < 32) begin
        got_d[got_n] = DELTA;
        got_o[got_n] = OUTER;
        got_n++;
      end
      tick();
    end
    ADV_ACK = 1'b0;
    check({name, "_done_seen"}, 16'(seen_done), 16'h1);
    check({name, "_busy_at_done"}, 16'(BUSY), 16'h0);
    tick();
    check({name, "_done_one_cycle"}, 16'(DONE), 16'h0);
  endtask

  // Expected deltas are listed first-request-first in a 72-bit vector.
  task automatic verify_seq(input string name, input logic [71:0] ed, input logic [7:0] eo);
    check({name, "_count"}, 16'(got_n), 16'd8);
    for (int i = 0; i < 8 && i < got_n; i++) begin
      check($sformatf("%s_delta%0d", name, i), 16'(got_d[i]), 16'(ed[(7-i)*9 +: 9]));
      check($sformatf("%s_outer%0d", name, i), 16'(got_o[i]), 16'(eo[7-i]));
    end
  endtask

  initial begin
    RESETL = 1'b0; ID = '0;
    LDSTPL = 1'b1; LDMODL = 1'b1; LDINNL = 1'b1; LDOUTL = 1'b1;
    START = 1'b0; ABORT = 1'b0; ADV_ACK = 1'b0;
    #12;
    check("rst_outputs", {STEP, STEPM1, YFRAC, BUSY, ADV_REQ, OUTER, DONE, 1'b0}, 16'h0);
    check("rst_delta", 16'(DELTA), 16'h0);
    RESETL = 1'b1;
    tick();

    // Normal stepping
    setup(8'h10, 1'b0, 1'b0, 8'd3, 8'd2);
    check("step_written", 16'(STEP), 16'h10);
    run_collect("norm");
    verify_seq("norm", {9'h001, 9'h001, 9'h001, 9'h010, 9'h001, 9'h001, 9'h001, 9'h010},
               8'b0001_0001);

    // Negative step with stalled handshake
    setup(8'h10, 1'b1, 1'b0, 8'd1, 8'd1);
    check("mode_stepm1", 16'(STEPM1), 16'h1);
    START = 1'b1; tick(); START = 1'b0;
    tick(); tick();
    check("neg_req_held", 16'(ADV_REQ), 16'h1);
    check("neg_inner_delta", 16'(DELTA), 16'h001);
    check("neg_inner_flag", 16'(OUTER), 16'h0);
    ADV_ACK = 1'b1; tick(); ADV_ACK = 1'b0;
    check("neg_outer_delta", 16'(DELTA), 16'h1F0);
    tick();
    check("neg_outer_stable", 16'(DELTA), 16'h1F0);
    check("neg_outer_flag", 16'(OUTER), 16'h1);
    ADV_ACK = 1'b1; tick(); ADV_ACK = 1'b0;
    check("neg_done", 16'(DONE), 16'h1);
    tick();

    // Y-fraction, positive and negative
    setup(8'h80, 1'b0, 1'b1, 8'd1, 8'd4);
    check("mode_yfrac", 16'(YFRAC), 16'h1);
    run_collect("yf");
    verify_seq("yf", {9'h001, 9'h000, 9'h001, 9'h001, 9'h001, 9'h000, 9'h001, 9'h001},
               8'b0101_0101);
    setup(8'h80, 1'b1, 1'b1, 8'd1, 8'd4);
    run_collect("yfm1");
    verify_seq("yfm1", {9'h001, 9'h000, 9'h001, 9'h1FF, 9'h001, 9'h000, 9'h001, 9'h1FF},
               8'b0101_0101);

    // Zero count
    setup(8'h10, 1'b0, 1'b0, 8'd0, 8'd2);
    ADV_ACK = 1'b1;
    START = 1'b1; tick(); START = 1'b0;
    check("zero_done", 16'(DONE), 16'h1);
    check("zero_no_req", 16'(ADV_REQ), 16'h0);
    check("zero_not_busy", 16'(BUSY), 16'h0);
    tick();
    check("zero_done_clear", 16'(DONE), 16'h0);
    check("zero_still_no_req", 16'(ADV_REQ), 16'h0);
    ADV_ACK = 1'b0;

    // Abort coincident with an ack, plus write while busy
    setup(8'h10, 1'b0, 1'b0, 8'd3, 8'd2);
    START = 1'b1; tick(); START = 1'b0;
    ID = 8'h55; LDSTPL = 1'b0; tick(); LDSTPL = 1'b1;
    check("busy_write_ignored", 16'(STEP), 16'h10);
    ABORT = 1'b1; ADV_ACK = 1'b1; tick(); ABORT = 1'b0; ADV_ACK = 1'b0;
    check("abort_req", 16'(ADV_REQ), 16'h0);
    check("abort_busy", 16'(BUSY), 16'h0);
    check("abort_no_done", 16'(DONE), 16'h0);
    tick();
    check("abort_no_done_late", 16'(DONE), 16'h0);

    // Asynchronous reset mid-sequence
    START = 1'b1; tick(); START = 1'b0;
    check("pre_reset_req", 16'(ADV_REQ), 16'h1);
    #2 RESETL = 1'b0;
    #1;
    check("async_rst_outputs", {STEP, STEPM1, YFRAC, BUSY, ADV_REQ, OUTER, DONE, 1'b0}, 16'h0);
    check("async_rst_delta", 16'(DELTA), 16'h0);
    RESETL = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
